prbs_checker: RTL
=================

# prbs_checker

PRBS9 receive-side checker for the DSP test path. Consumes the serial stream produced by the x^9+x^5+1 generator and self-synchronises a local 9-bit LFSR to it. Once locked, it flags every bit error, counts bits and errors for BER measurement, and drops lock when the error density in a 64-bit window exceeds a threshold.

## Interface
- LOCK_LEN, 16: consecutive correct predictions in SEARCH required to declare lock (1..255)
- LOSS_ERRS, 8: errors within one 64-bit LOCKED window that force loss of lock (1..64)
- CNT_W, 32: width of bit_count / err_count
- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  block enable; qualifies bit_in together with valid
- valid  in  1  bit_in carries a new bit this cycle
- bit_in  in  1  received serial PRBS bit
- clr_cnt  in  1  synchronous clear of bit_count / err_count
- locked  out  1  checker is in LOCKED state
- err  out  1  one-cycle pulse: last qualified bit mismatched while LOCKED
- bit_count  out  CNT_W  qualified bits checked while LOCKED, saturating
- err_count  out  CNT_W  errors detected while LOCKED, saturating

## Operation
- Qualified bit: enable & valid high on a clk edge; nothing changes otherwise, and err is low on the following cycle.
- Local register lfsr[8:0] uses generator orientation: predicted = lfsr[0]^lfsr[4]; lfsr[8] holds the newest bit.
- States: SEARCH, LOCKED (2-bit encoding from package, one spare).
- SEARCH on a qualified bit:
  - lfsr <= {bit_in, lfsr[8:1]} (loads received data).
  - fill counter counts up to 9, then saturates.
  - Once fill = 9: if bit_in == predicted and lfsr != 0, match_cnt increments; otherwise match_cnt <= 0.
  - When match_cnt reaches LOCK_LEN: go to LOCKED and clear the window counters.
  - The all-zero guard prevents locking on a stuck-at-0 line.
- LOCKED on a qualified bit:
  - lfsr <= {predicted, lfsr[8:1]}, so it free-runs and received errors do not propagate.
  - err <= (bit_in != predicted).
  - bit_count increments by 1; err_count increments on a mismatch.
  - win_cnt (6 bits) increments; win_err increments on a mismatch.
- Loss of lock: if win_err, including the current bit, reaches LOSS_ERRS, go to SEARCH with fill, match_cnt, win_cnt and win_err cleared. The lfsr keeps its value and reloads from data.
- Window wrap: when win_cnt wraps 63 -> 0, win_err <= 0. An error on the 64th bit is evaluated against the ending window first.
- Counters saturate at all-ones. clr_cnt has priority over a simultaneous increment and works in any state.
- Reset: state SEARCH, lfsr = 0, all counters 0, locked = 0, err = 0, bit_count = 0, err_count = 0.
- Asserting rst mid-stream aborts immediately. Relock requires 9 + LOCK_LEN qualified bits.

## Timing
- All outputs are registered.
- err pulses on the cycle after the qualified bit edge, for exactly one cycle.
- locked rises on the edge that registers the LOCK_LEN-th match, i.e. after qualified bit 9 + LOCK_LEN from reset on a clean stream.
- locked falls on the edge that registers the LOSS_ERRS-th window error. err is also high for that bit.
- bit_count and err_count update on the same edge as err.

## Configuration
- PRBS_CHECKER_ERR_CNT_EN defined: bit_count, err_count and clr_cnt logic are present as described.
- Undefined: both counter outputs are tied to 0 and clr_cnt is ignored. Lock and err behaviour is unchanged.

## Structure
- Shared package prbs_pkg contains:
  - PRBS_LEN = 9
  - tap indices TAP_A = 0, TAP_B = 4
  - state encoding ST_SEARCH / ST_LOCKED
  - WIN_LEN = 64
- Sub-module sat_counter (parameter W; inputs inc and clr, clr wins; saturating output). It is instantiated for bit_count and err_count, and is also usable for match_cnt.

## Test plan
- Clean PRBS9 stream from generator seed 9'h1FF, LOCK_LEN = 16 -> locked rises after qualified bit 25; err stays 0; after 1000 more bits, bit_count = 1000 and err_count = 0.
- While LOCKED, invert 3 isolated bits -> exactly 3 single-cycle err pulses, err_count = 3, locked stays 1, no error propagation.
- All-zero input (generator seed 0) for 200 bits -> locked stays 0, counters 0.
- While LOCKED, invert 8 bits within one 64-bit window, LOSS_ERRS = 8 -> locked falls with the 8th err pulse. The clean stream then relocks after 25 further bits.
- Toggle valid/enable low for random gaps on a clean stream -> same lock point in qualified-bit terms, no err, bit_count counts only qualified bits.
- clr_cnt asserted in the same cycle as an error, then rst asserted mid-LOCKED -> counters read 0 after the clr, and all outputs are 0 right after rst.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared PRBS9 constants, FSM encoding and the tap-prediction helper
// used by the prbs_checker block.
package prbs_pkg;

  localparam int PRBS_LEN = 9;
  localparam int TAP_A    = 0;
  localparam int TAP_B    = 4;
  localparam int WIN_LEN  = 64;

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_LOCKED = 2'b01;

  // x^9+x^5+1 in generator orientation: oldest bit at [0], newest at [8].
  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] state);
    return state[TAP_A] ^ state[TAP_B];
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream and status bundle between a PRBS source/monitor (master)
// and the prbs_checker (slave).
interface prbs_checker_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             valid;
  logic             bit_in;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output enable, valid, bit_in, clr_cnt,
    input  locked, err, bit_count, err_count
  );

  modport slave (
    input  enable, valid, bit_in, clr_cnt,
    output locked, err, bit_count, err_count
  );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority
// over increment; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] FULL = {W{1'b1}};

  // Count register: clear wins, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= ZERO;
    end else if (clr) begin
      count <= ZERO;
    end else if (inc && (count != FULL)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 receive checker: self-synchronising LFSR, lock/loss FSM and
// BER counters. Counters exist only with PRBS_CHECKER_ERR_CNT_EN defined.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_LEN  = 16,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  prbs_checker_if.slave bus
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [7:0]       LOCK_V   = LOCK_LEN[7:0];
  localparam logic [WIN_W:0]   LOSS_V   = LOSS_ERRS[WIN_W:0];
  localparam logic [WIN_W-1:0] WIN_LAST = {WIN_W{1'b1}};

  logic [1:0]          state_r,   state_n;
  logic [PRBS_LEN-1:0] lfsr_r,    lfsr_n;
  logic [3:0]          fill_r,    fill_n;
  logic [WIN_W-1:0]    win_cnt_r, win_cnt_n;
  logic [WIN_W:0]      win_err_r, win_err_n;
  logic [WIN_W:0]      win_sum_s;
  logic [7:0]          match_r;
  logic                locked_r;
  logic                err_r,     err_n;
  logic                pred_s;
  logic                qual_s;
  logic                mism_s;
  logic                match_inc_s;
  logic                match_clr_s;
  logic                bit_inc_s;
  logic                err_inc_s;
  logic [CNT_W-1:0]    bit_cnt_s;
  logic [CNT_W-1:0]    err_cnt_s;

  // Next-state decode for the lock FSM, LFSR and window counters.
  always_comb begin
    pred_s      = prbs_predict(lfsr_r);
    qual_s      = bus.enable & bus.valid;
    mism_s      = bus.bit_in ^ pred_s;
    win_sum_s   = win_err_r + {{WIN_W{1'b0}}, mism_s};
    state_n     = state_r;
    lfsr_n      = lfsr_r;
    fill_n      = fill_r;
    win_cnt_n   = win_cnt_r;
    win_err_n   = win_err_r;
    err_n       = 1'b0;
    match_inc_s = 1'b0;
    match_clr_s = 1'b0;
    bit_inc_s   = 1'b0;
    err_inc_s   = 1'b0;
    if (qual_s) begin
      case (state_r)
        ST_SEARCH: begin
          lfsr_n = {bus.bit_in, lfsr_r[PRBS_LEN-1:1]};
          if (fill_r != 4'd9) begin
            fill_n = fill_r + 4'd1;
          end else if (!mism_s && (lfsr_r != {PRBS_LEN{1'b0}})) begin
            match_inc_s = 1'b1;
            if ((match_r + 8'd1) == LOCK_V) begin
              state_n     = ST_LOCKED;
              match_clr_s = 1'b1;
              win_cnt_n   = {WIN_W{1'b0}};
              win_err_n   = {(WIN_W+1){1'b0}};
            end else begin
              state_n = ST_SEARCH;
            end
          end else begin
            match_clr_s = 1'b1;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so a received error cannot poison the state.
          lfsr_n    = {pred_s, lfsr_r[PRBS_LEN-1:1]};
          err_n     = mism_s;
          bit_inc_s = 1'b1;
          err_inc_s = mism_s;
          if (win_sum_s >= LOSS_V) begin
            state_n     = ST_SEARCH;
            fill_n      = 4'd0;
            match_clr_s = 1'b1;
            win_cnt_n   = {WIN_W{1'b0}};
            win_err_n   = {(WIN_W+1){1'b0}};
          end else if (win_cnt_r == WIN_LAST) begin
            win_cnt_n = {WIN_W{1'b0}};
            win_err_n = {(WIN_W+1){1'b0}};
          end else begin
            win_cnt_n = win_cnt_r + {{(WIN_W-1){1'b0}}, 1'b1};
            win_err_n = win_sum_s;
          end
        end
        default: begin
          state_n     = ST_SEARCH;
          fill_n      = 4'd0;
          match_clr_s = 1'b1;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, LFSR, window and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_SEARCH;
      lfsr_r    <= {PRBS_LEN{1'b0}};
      fill_r    <= 4'd0;
      win_cnt_r <= {WIN_W{1'b0}};
      win_err_r <= {(WIN_W+1){1'b0}};
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      lfsr_r    <= lfsr_n;
      fill_r    <= fill_n;
      win_cnt_r <= win_cnt_n;
      win_err_r <= win_err_n;
      locked_r  <= (state_n == ST_LOCKED);
      err_r     <= err_n;
    end
  end

  sat_counter #(.W(8)) u_match (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_inc_s),
    .clr   (match_clr_s),
    .count (match_r)
  );

`ifdef PRBS_CHECKER_ERR_CNT_EN
  sat_counter #(.W(CNT_W)) u_bit_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_inc_s),
    .clr   (bus.clr_cnt),
    .count (bit_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc_s),
    .clr   (bus.clr_cnt),
    .count (err_cnt_s)
  );
`else
  logic unused_cnt_s;
  assign unused_cnt_s = bus.clr_cnt ^ bit_inc_s ^ err_inc_s;
  assign bit_cnt_s    = {CNT_W{1'b0}};
  assign err_cnt_s    = {CNT_W{1'b0}};
`endif

  assign bus.locked    = locked_r;
  assign bus.err       = err_r;
  assign bus.bit_count = bit_cnt_s;
  assign bus.err_count = err_cnt_s;

endmodule
